// File: rtl/rv32v_types_pkg.sv
// Shared vector-unit types and helpers.
// Contents:
//   valuop_t    - ALU operation selected by decode
//   vsew_t      - selected element width encoding
//   red_state_t - reduction unit sequencing states
//   sew_mask()  - bit mask covering the significant bits of an element
//   is_red_op() - whether an ALU op is meaningful as a reduction
package rv32v_types_pkg;

  localparam int ELEM_W = 32;

  typedef enum logic [3:0] {
    VALU_ADD = 4'd0,
    VALU_SUB = 4'd1,
    VALU_AND = 4'd2,
    VALU_OR  = 4'd3,
    VALU_XOR = 4'd4,
    VALU_MIN = 4'd5,
    VALU_MAX = 4'd6,
    VALU_SLL = 4'd7,
    VALU_SRL = 4'd8,
    VALU_SRA = 4'd9
  } valuop_t;

  // Encodings beyond SEW32 (including the unnamed ones) are treated as 32-bit.
  typedef enum logic [2:0] {
    SEW8  = 3'd0,
    SEW16 = 3'd1,
    SEW32 = 3'd2,
    SEW64 = 3'd3
  } vsew_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } red_state_t;

  function automatic logic [ELEM_W-1:0] sew_mask(input vsew_t sew);
    logic [ELEM_W-1:0] m;
    case (sew)
      SEW8:    m = 32'h0000_00FF;
      SEW16:   m = 32'h0000_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

  function automatic logic is_red_op(input valuop_t op);
    logic legal;
    case (op)
      VALU_ADD, VALU_AND, VALU_OR, VALU_XOR, VALU_MIN, VALU_MAX: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/rv32v_red_fold.sv
// One combinational fold step of a reduction: combines the running
// accumulator with a single element under the latched op/width controls.
// Ports:
//   acc_i      - running accumulator (already SEW-truncated)
//   elem_i     - element slot; only the low SEW bits are significant
//   active_i   - lane active; an inactive lane passes the accumulator through
//   op_i       - reduction operation
//   unsigned_i - MIN/MAX compare as unsigned when high
//   sew_i      - element width
//   acc_o      - next accumulator value, SEW-truncated
module rv32v_red_fold
  import rv32v_types_pkg::*;
(
  input  logic [31:0] acc_i,
  input  logic [31:0] elem_i,
  input  logic        active_i,
  input  valuop_t     op_i,
  input  logic        unsigned_i,
  input  vsew_t       sew_i,
  output logic [31:0] acc_o
);

  logic [31:0] mask;
  logic [31:0] accT;
  logic [31:0] elemT;
  logic [31:0] result;
  logic [32:0] accX;
  logic [32:0] elemX;
  logic        accSign;
  logic        elemSign;
  logic        accLess;

  // Both operands are truncated to SEW, then widened to 33 bits so that a
  // single signed comparator serves signed and unsigned MIN/MAX alike.
  always_comb begin
    mask  = sew_mask(sew_i);
    accT  = acc_i & mask;
    elemT = elem_i & mask;

    case (sew_i)
      SEW8: begin
        accSign  = accT[7];
        elemSign = elemT[7];
      end
      SEW16: begin
        accSign  = accT[15];
        elemSign = elemT[15];
      end
      default: begin
        accSign  = accT[31];
        elemSign = elemT[31];
      end
    endcase

    accX  = {1'b0, accT};
    elemX = {1'b0, elemT};
    if (!unsigned_i && accSign)  accX  = {1'b1, accT | ~mask};
    if (!unsigned_i && elemSign) elemX = {1'b1, elemT | ~mask};
    accLess = $signed(accX) < $signed(elemX);

    case (op_i)
      VALU_ADD: result = (accT + elemT) & mask;
      VALU_AND: result = accT & elemT;
      VALU_OR:  result = accT | elemT;
      VALU_XOR: result = accT ^ elemT;
      VALU_MIN: result = accLess ? accT : elemT;
      VALU_MAX: result = accLess ? elemT : accT;
      default:  result = accT;
    endcase

    acc_o = active_i ? result : accT;
  end

endmodule

// File: rtl/rv32v_red_unit.sv
// Vector reduction execution unit. Latches the op and scalar seed on start,
// folds each accepted beat of LANES elements into one SEW-wide accumulator,
// and offers the scalar result to writeback with a valid/ready handshake.
// Ports:
//   clk_i, rst_i        - clock, synchronous active-high reset
//   start_i, vl_zero_i  - begin a reduction (IDLE only); vl_zero_i means no beats follow
//   valuop_i, vopunsigned_i, vsew_i, scalar_init_i - op controls and vs1[0] seed
//   elem_valid_i/elem_ready_o/elem_data_i/elem_mask_i/elem_last_i - beat stream
//   res_valid_o/res_ready_i/res_data_o/res_illegal_o - result handshake
//   busy_o              - unit is not idle
module rv32v_red_unit
  import rv32v_types_pkg::*;
#(
  parameter int LANES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  vl_zero_i,
  input  valuop_t               valuop_i,
  input  logic                  vopunsigned_i,
  input  vsew_t                 vsew_i,
  input  logic [31:0]           scalar_init_i,
  input  logic                  elem_valid_i,
  output logic                  elem_ready_o,
  input  logic [32*LANES-1:0]   elem_data_i,
  input  logic [LANES-1:0]      elem_mask_i,
  input  logic                  elem_last_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [31:0]           res_data_o,
  output logic                  res_illegal_o,
  output logic                  busy_o
);

  red_state_t  state_q, state_d;
  logic [31:0] acc_q, acc_d;
  valuop_t     op_q, op_d;
  logic        uns_q, uns_d;
  vsew_t       sew_q, sew_d;
  logic        illegal_q, illegal_d;
  logic [31:0] foldAcc;

  // Lane folds are chained so lane 0 is applied first; each stage has its
  // own nets so the chain has no apparent combinational loop.
  for (genvar g = 0; g < LANES; g++) begin : gen_lane
    logic [31:0] stageIn;
    logic [31:0] stageOut;

    if (g == 0) begin : gen_first
      assign stageIn = acc_q;
    end else begin : gen_rest
      assign stageIn = gen_lane[g-1].stageOut;
    end

    rv32v_red_fold u_fold (
      .acc_i      (stageIn),
      .elem_i     (elem_data_i[32*g +: 32]),
      .active_i   (elem_mask_i[g]),
      .op_i       (op_q),
      .unsigned_i (uns_q),
      .sew_i      (sew_q),
      .acc_o      (stageOut)
    );
  end

  assign foldAcc = gen_lane[LANES-1].stageOut;

  // Next-state and output decode. An illegal op still walks through ACCUM
  // and consumes beats, but never touches the accumulator, so the seed is
  // what comes back.
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    op_d          = op_q;
    uns_d         = uns_q;
    sew_d         = sew_q;
    illegal_d     = illegal_q;
    elem_ready_o  = 1'b0;
    res_valid_o   = 1'b0;
    res_data_o    = 32'd0;
    res_illegal_o = 1'b0;
    busy_o        = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (start_i) begin
          op_d      = valuop_i;
          uns_d     = vopunsigned_i;
          sew_d     = vsew_i;
          illegal_d = !is_red_op(valuop_i);
          acc_d     = scalar_init_i & sew_mask(vsew_i);
          state_d   = vl_zero_i ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        elem_ready_o = 1'b1;
        if (elem_valid_i) begin
          if (!illegal_q) acc_d = foldAcc;
          if (elem_last_i) state_d = DONE;
        end
      end
      DONE: begin
        res_valid_o   = 1'b1;
        res_data_o    = acc_q;
        res_illegal_o = illegal_q;
        if (res_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any reduction in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      acc_q     <= 32'd0;
      op_q      <= VALU_ADD;
      uns_q     <= 1'b0;
      sew_q     <= SEW8;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      op_q      <= op_d;
      uns_q     <= uns_d;
      sew_q     <= sew_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: doc/rv32v_red_unit.md
Name: rv32v_red_unit

Overview:
- Reduction execution unit: the consumer of decoded control where decode selects vfu = VFU_RED.
- Receives valuop, vopunsigned and vsew with a start pulse, plus the scalar seed vs1[0].
- Folds vs2 element beats from the lane datapath into a single SEW-wide accumulator.
- Returns the scalar result to the writeback stage through a valid/ready handshake.

Parameters:
- LANES, 2, elements delivered per beat (each in a 32-bit slot, low SEW bits significant).

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous reset, active-high
- start  in  1  begin a reduction; sampled only in IDLE
- vl_zero  in  1  qualifies start: vl = 0, so no beats will follow
- valuop  in  valuop_t  operation; legal: VALU_ADD, AND, OR, XOR, MIN, MAX
- vopunsigned  in  1  unsigned compare for MIN/MAX
- vsew  in  vsew_t  element width (SEW8/16/32)
- scalar_init  in  32  vs1[0] seed
- elem_valid  in  1  beat valid
- elem_ready  out  1  beat accepted when high with elem_valid
- elem_data  in  32*LANES  lane i in bits [32i+31:32i]
- elem_mask  in  LANES  1 = lane active (mask and body combined upstream)
- elem_last  in  1  final beat of the reduction
- res_valid  out  1  result available
- res_ready  in  1  writeback accepts the result
- res_data  out  32  result, low SEW bits; upper bits zero
- res_illegal  out  1  valuop was not a legal reduction op
- busy  out  1  state != IDLE

Behaviour:
- Reset values: state = IDLE; acc = 0; all outputs 0. RST mid-operation aborts the reduction and discards any pending result.
- FSM IDLE:
  - start=1, vl_zero=0 → ACCUM.
  - start=1, vl_zero=1 → DONE.
  - On either start: latch op, unsigned flag, sew and legality; acc = scalar_init truncated to SEW.
- FSM ACCUM:
  - elem_ready = 1. Each handshake folds all active lanes, in order lane 0..LANES-1, into acc.
  - Inactive lanes contribute nothing (identity).
  - A handshake with elem_last=1 → DONE on the next edge. elem_valid=0 holds state.
- FSM DONE:
  - res_valid = 1; res_data = acc zero-extended from SEW.
  - res_valid=1 and res_ready=1 → IDLE. The result is held stable while res_ready=0.
- start is ignored outside IDLE. elem_ready = 0 in IDLE and DONE.
- Latency:
  - res_valid asserts the cycle after the last beat's handshake.
  - With vl_zero, res_valid asserts the cycle after start.
- Width rules:
  - Operands are truncated to SEW, then sign- or zero-extended to 33 bits for MIN/MAX. Zero-extension applies when vopunsigned=1.
  - ADD wraps modulo 2^SEW.
  - vsew encodings above SEW32 behave as SEW32.
- Illegal valuop:
  - The FSM still sequences normally and beats are consumed.
  - acc is never modified, so the result is the truncated seed, and res_illegal = 1 alongside res_valid.
- A beat with all lanes masked leaves acc unchanged, but elem_last still terminates the reduction.

Decomposition:
- rv32v_types_pkg supplies valuop_t and vsew_t.
- Add red_state_t (IDLE, ACCUM, DONE) to rv32v_types_pkg.
- Add function sew_mask(vsew_t) to rv32v_types_pkg.
- Sub-module rv32v_red_fold: combinational fold of acc, one element and the op/sew/unsigned controls into the next acc. Instantiate LANES copies, chained.

Test Plan:
- ADD, SEW32, seed 10, beats {1,2},{3,4} with last on the 2nd beat, mask 2'b11 → res_data = 20, one cycle after the 2nd handshake.
- MAXU vs MAX, SEW8, seed 0x01, beat {0xFF,0x7F} → unsigned result 0xFF; signed result 0x7F.
- ADD SEW8 wraparound: seed 0xF0, beat {0x20,0x01}, mask 2'b01 → res_data = 0x10; masked lane ignored.
- vl_zero start with seed 0x1234, SEW16 → res_valid next cycle, res_data = 0x1234, no elem_ready asserted.
- res_ready held low 5 cycles in DONE → res_data stable. start pulses during ACCUM/DONE ignored. RST asserted in ACCUM → all outputs 0 next cycle.
- Illegal valuop (VALU_SUB), seed 7, one beat {5,5} with last → res_data = 7, res_illegal = 1.
